// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the K=3 rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K = 3;
    localparam int NUM_STATES = 4;
    localparam logic [2:0] G0_DEF = 3'b111;
    localparam logic [2:0] G1_DEF = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACS,
        TRACE,
        DONE
    } vit_state_e;

    // Branch label {G0 symbol, G1 symbol} for input u leaving state s.
    function automatic logic [1:0] sym_bits(
        input logic [2:0] g0,
        input logic [2:0] g1,
        input logic       u,
        input logic [1:0] s
    );
        logic [2:0] r;
        r = {u, s};
        return {^(g0 & r), ^(g1 & r)};
    endfunction

    function automatic logic [1:0] hamming2(
        input logic [1:0] a,
        input logic [1:0] b
    );
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one trellis state; ties resolve to the even predecessor.
module viterbi_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W-1:0] sum0;
    logic [PM_W-1:0] sum1;

    always_comb begin
        sum0   = pm0 + PM_W'(bm0);
        sum1   = pm1 + PM_W'(bm1);
        dec    = sum1 < sum0;
        pm_new = dec ? sum1 : sum0;
    end

endmodule

// File: rtl/viterbi_decoder_param.sv
// Block-mode Viterbi decoder: captures a frame, runs N ACS steps, then N trace-back steps.
module viterbi_decoder_param
    import viterbi_pkg::*;
#(
    parameter int         MSG_LEN   = 8,
    parameter logic [2:0] G0        = G0_DEF,
    parameter logic [2:0] G1        = G1_DEF,
    parameter bit         TAIL_ZERO = 1'b1,
    localparam int        PM_W      = $clog2(4*MSG_LEN+2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [2*MSG_LEN-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [MSG_LEN-1:0]   out_data,
    output logic [PM_W-1:0]      out_metric,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done_flag
);

    localparam int FW    = 2*MSG_LEN;
    localparam int CNT_W = $clog2(MSG_LEN);
    localparam logic [PM_W-1:0]  INF  = PM_W'(2*MSG_LEN+1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MSG_LEN-1);

    typedef logic [NUM_STATES-1:0][PM_W-1:0] pm_t;
    localparam pm_t PM_INIT = {INF, INF, INF, PM_W'(0)};

    vit_state_e                        state_q, state_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic [FW-1:0]                     frame_q, frame_d;
    pm_t                               pm_q, pm_d, acs_pm;
    logic [MSG_LEN-1:0][NUM_STATES-1:0] dec_q, dec_d;
    logic [NUM_STATES-1:0]             acs_dec;
    logic [1:0]                        tb_q, tb_d, tb_cur, best;
    logic                              first_q, first_d;
    logic [MSG_LEN-1:0]                data_q, data_d;
    logic [PM_W-1:0]                   metric_q, metric_d;
    logic                              in_ready_q, in_ready_d;
    logic                              out_valid_q, out_valid_d;
    logic                              done_q, done_d;
    logic [1:0]                        pair;

    assign pair = frame_q[FW-1 -: 2];

    // Next state ns is reached from {ns[0],0} and {ns[0],1} with input ns[1].
    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};
        logic [1:0] bm0;
        logic [1:0] bm1;
        assign bm0 = hamming2(pair, sym_bits(G0, G1, NS[1], P0));
        assign bm1 = hamming2(pair, sym_bits(G0, G1, NS[1], P1));
        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0    (pm_q[P0]),
            .pm1    (pm_q[P1]),
            .bm0    (bm0),
            .bm1    (bm1),
            .pm_new (acs_pm[g]),
            .dec    (acs_dec[g])
        );
    end

    always_comb begin
        best = 2'd0;
        if (!TAIL_ZERO) begin
            for (int i = 1; i < NUM_STATES; i++) begin
                if (pm_q[i] < pm_q[best]) best = 2'(i);
            end
        end
        tb_cur = first_q ? best : tb_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        pm_d     = pm_q;
        dec_d    = dec_q;
        tb_d     = tb_q;
        first_d  = first_q;
        data_d   = data_q;
        metric_d = metric_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    frame_d = in_data;
                    pm_d    = PM_INIT;
                    cnt_d   = '0;
                    state_d = ACS;
                end
            end
            ACS: begin
                frame_d        = frame_q << 2;
                pm_d           = acs_pm;
                dec_d[cnt_q]   = acs_dec;
                if (cnt_q == LAST) begin
                    first_d = 1'b1;
                    state_d = TRACE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRACE: begin
                first_d              = 1'b0;
                data_d[LAST - cnt_q] = tb_cur[1];
                tb_d                 = {tb_cur[0], dec_q[cnt_q][tb_cur]};
                if (first_q) metric_d = pm_q[tb_cur];
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = state_d == IDLE;
        out_valid_d = state_d == DONE;
        done_d      = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            pm_q        <= PM_INIT;
            dec_q       <= '0;
            tb_q        <= '0;
            first_q     <= 1'b0;
            data_q      <= '0;
            metric_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else if (en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            pm_q        <= pm_d;
            dec_q       <= dec_d;
            tb_q        <= tb_d;
            first_q     <= first_d;
            data_q      <= data_d;
            metric_q    <= metric_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign done_flag  = done_q;
    assign out_data   = data_q;
    assign out_metric = metric_q;

endmodule

// File: tb/tb_viterbi_decoder_param.sv
// Self-checking bench: directed vector table, corner sequences and random frames vs a reference decoder.
module tb_viterbi_decoder_param;

    localparam int N   = 8;
    localparam int PMW = $clog2(4*N+2);
    localparam int INF = 2*N+1;

    logic           clk = 0;
    logic           rst_n = 0;
    logic           en = 1;
    logic [2*N-1:0] in_data = '0;
    logic           in_valid = 0;
    logic           in_ready;
    logic [N-1:0]   out_data;
    logic [PMW-1:0] out_metric;
    logic           out_valid;
    logic           out_ready = 0;
    logic           done_flag;

    int n_checks = 0;
    int n_fail = 0;

    viterbi_decoder_param #(
        .MSG_LEN   (N),
        .G0        (3'b111),
        .G1        (3'b101),
        .TAIL_ZERO (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_metric (out_metric),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done_flag  (done_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int parity(input int v);
        return (v & 1) ^ ((v >> 1) & 1) ^ ((v >> 2) & 1);
    endfunction

    function automatic logic [2*N-1:0] encode(input logic [N-1:0] msg);
        int s;
        int u;
        int r;
        logic [2*N-1:0] f;
        s = 0;
        f = '0;
        for (int t = 0; t < N; t++) begin
            u = int'(msg[N-1-t]);
            r = 4*u + s;
            f[2*N-1-2*t] = 1'(parity(7 & r));
            f[2*N-2-2*t] = 1'(parity(5 & r));
            s = 2*u + (s >> 1);
        end
        return f;
    endfunction

    // Textbook Viterbi over integer metrics with explicit predecessor table.
    function automatic void ref_decode(input logic [2*N-1:0] fr,
                                       output logic [N-1:0] bits, output int metric);
        int pm[4];
        int npm[4];
        int pred[N][4];
        int ns, cost, c0, c1, r0, r1, s;
        pm = '{0, INF, INF, INF};
        for (int t = 0; t < N; t++) begin
            r0 = int'(fr[2*N-1-2*t]);
            r1 = int'(fr[2*N-2-2*t]);
            for (int i = 0; i < 4; i++) npm[i] = 1 << 20;
            for (int p = 0; p < 4; p++) begin
                for (int u = 0; u < 2; u++) begin
                    ns = 2*u + p/2;
                    c0 = parity(7 & (4*u + p));
                    c1 = parity(5 & (4*u + p));
                    cost = pm[p] + ((r0 != c0) ? 1 : 0) + ((r1 != c1) ? 1 : 0);
                    if (cost < npm[ns]) begin
                        npm[ns] = cost;
                        pred[t][ns] = p;
                    end
                end
            end
            pm = npm;
        end
        s = 0;
        metric = pm[0];
        bits = '0;
        for (int t = N-1; t >= 0; t--) begin
            bits[N-1-t] = 1'((s >> 1) & 1);
            s = pred[t][s];
        end
    endfunction

    task automatic run_frame(input logic [2*N-1:0] din, input int stall_at, input int stall_len,
                             output logic [N-1:0] dq, output logic [PMW-1:0] mq,
                             output int lat, output int dones);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 0, 1);
        in_data = din;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        in_data = 16'($urandom);
        lat = 0;
        dones = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (stall_at != 0 && lat == stall_at) en = 0;
            if (stall_at != 0 && lat == stall_at + stall_len) en = 1;
            @(negedge clk);
            if (done_flag) dones++;
            if (out_valid) break;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
        dq = out_data;
        mq = out_metric;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [2*N-1:0] din;
        logic [N-1:0]   dout;
        logic [PMW-1:0] metric;
    } vec_t;

    vec_t vecs[3];

    initial begin
        logic [N-1:0]   dq, msg, edata;
        logic [PMW-1:0] mq;
        logic [2*N-1:0] fr;
        int lat, dones, guard, gap, cnt, emet, nerr;

        vecs[0] = '{16'hE170, 8'hB0, 6'd0};
        vecs[1] = '{16'h6170, 8'hB0, 6'd1};
        vecs[2] = '{16'h0000, 8'h00, 6'd0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_done", 32'(done_flag), 0);
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_out_valid", 32'(out_valid), 0);
        chk("post_rst_done", 32'(done_flag), 0);
        chk("post_rst_data", 32'(out_data), 0);
        chk("post_rst_metric", 32'(out_metric), 0);

        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i].din, 0, 0, dq, mq, lat, dones);
            chk($sformatf("vec%0d_data", i), 32'(dq), 32'(vecs[i].dout));
            chk($sformatf("vec%0d_metric", i), 32'(mq), 32'(vecs[i].metric));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 16);
            chk($sformatf("vec%0d_done_pulses", i), 32'(dones), 1);
        end

        // Back-to-back frames with out_ready tied high and in_valid held through DONE.
        out_ready = 1;
        in_data = 16'h0000;
        in_valid = 1;
        @(posedge clk);
        #1 in_data = 16'hE170;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_first_valid", 32'(out_valid), 1);
        chk("b2b_first_data", 32'(out_data), 32'h00);
        chk("b2b_busy_in_ready", 32'(in_ready), 0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!out_valid && gap < 100);
        in_valid = 0;
        chk("b2b_second_data", 32'(out_data), 32'hB0);
        chk("b2b_period", 32'(gap), 18);
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("b2b_idle_after", 32'(in_ready), 1);

        run_frame(16'hE170, 3, 5, dq, mq, lat, dones);
        chk("stall_acs_data", 32'(dq), 32'hB0);
        chk("stall_acs_latency", 32'(lat), 21);
        run_frame(16'hE170, 10, 5, dq, mq, lat, dones);
        chk("stall_trace_data", 32'(dq), 32'hB0);
        chk("stall_trace_metric", 32'(mq), 0);
        chk("stall_trace_latency", 32'(lat), 21);

        // Reset four edges after capture must discard the frame.
        in_data = 16'hE170;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("abort_no_output", 32'(cnt), 0);
        chk("abort_ready_after", 32'(in_ready), 1);
        run_frame(16'hE170, 0, 0, dq, mq, lat, dones);
        chk("abort_next_data", 32'(dq), 32'hB0);

        // Backpressure: result held for 10 cycles.
        in_data = 16'hE170;
        in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_first_done", 32'(done_flag), 1);
        dones = 0;
        repeat (10) begin
            if (done_flag) dones++;
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 32'hB0);
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        chk("bp_done_pulses", 32'(dones), 1);
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
        @(negedge clk);
        chk("bp_released_valid", 32'(out_valid), 0);
        chk("bp_released_ready", 32'(in_ready), 1);

        for (int k = 0; k < 40; k++) begin
            msg = N'($urandom);
            if ($urandom_range(1, 0) == 1) msg[1:0] = 2'b00;
            fr = encode(msg);
            nerr = $urandom_range(3, 0);
            for (int e = 0; e < nerr; e++) fr[$urandom_range(2*N-1, 0)] ^= 1'b1;
            if ($urandom_range(4, 0) == 0) fr = 16'($urandom);
            ref_decode(fr, edata, emet);
            run_frame(fr, 0, 0, dq, mq, lat, dones);
            chk($sformatf("rnd%0d_data_%h", k, fr), 32'(dq), 32'(edata));
            chk($sformatf("rnd%0d_metric_%h", k, fr), 32'(mq), 32'(emet));
            if (nerr == 0 && msg[1:0] == 2'b00 && fr == encode(msg)) begin
                chk($sformatf("rnd%0d_clean", k), 32'(dq), 32'(msg));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
